// File: rtl/branch_predictor_btb.sv
// rtl/branch_predictor_btb.sv - dynamic branch predictor with direct-mapped BTB
// Zero-latency IF lookup, MEM-stage resolution with mispredict/redirect and saturating stats.
module branch_predictor_btb #(
  parameter int XLEN    = 32,
  parameter int ENTRIES = 16,
  parameter int TAG_W   = 8,
  parameter int CNT_W   = 2,
  parameter int STAT_W  = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              flush_tables,
  input  logic [XLEN-1:0]   if_pc,
  output logic              pred_hit,
  output logic              pred_taken,
  output logic [XLEN-1:0]   pred_target,
  input  logic              upd_valid,
  input  logic [XLEN-1:0]   upd_pc,
  input  logic              upd_is_jump,
  input  logic              upd_no_alloc,
  input  logic              upd_taken,
  input  logic [XLEN-1:0]   upd_target,
  input  logic              upd_pred_taken,
  input  logic [XLEN-1:0]   upd_pred_target,
  output logic              mispredict,
  output logic [XLEN-1:0]   redirect_pc,
  output logic [STAT_W-1:0] stat_branches,
  output logic [STAT_W-1:0] stat_mispredicts
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_WEAK_NT = CNT_W'((1 << (CNT_W - 1)) - 1);
  localparam logic [CNT_W-1:0] CNT_WEAK_T  = CNT_W'(1 << (CNT_W - 1));
  localparam logic [STAT_W-1:0] STAT_MAX = '1;

  logic             validQ  [ENTRIES];
  logic [TAG_W-1:0] tagQ    [ENTRIES];
  logic [XLEN-1:0]  targetQ [ENTRIES];
  logic [CNT_W-1:0] cntQ    [ENTRIES];
  logic             jumpQ   [ENTRIES];

  logic [IDX_W-1:0] ifIdx;
  logic [TAG_W-1:0] ifTag;
  logic [IDX_W-1:0] updIdx;
  logic [TAG_W-1:0] updTag;
  logic             updHit;
  logic [CNT_W-1:0] cntCur;
  logic [CNT_W-1:0] cntNext;

  assign ifIdx  = if_pc[IDX_W+1:2];
  assign ifTag  = if_pc[IDX_W+TAG_W+1:IDX_W+2];
  assign updIdx = upd_pc[IDX_W+1:2];
  assign updTag = upd_pc[IDX_W+TAG_W+1:IDX_W+2];

  // Lookup reads pre-edge table contents; a same-cycle update is not bypassed.
  assign pred_hit    = validQ[ifIdx] && (tagQ[ifIdx] == ifTag);
  assign pred_taken  = pred_hit && (jumpQ[ifIdx] || cntQ[ifIdx][CNT_W-1]);
  assign pred_target = pred_taken ? targetQ[ifIdx] : if_pc + XLEN'(4);

  assign mispredict  = upd_valid && ((upd_taken != upd_pred_taken) ||
                                     (upd_taken && (upd_target != upd_pred_target)));
  assign redirect_pc = upd_taken ? upd_target : upd_pc + XLEN'(4);

  assign updHit = validQ[updIdx] && (tagQ[updIdx] == updTag);
  assign cntCur = cntQ[updIdx];

  always_comb begin
    cntNext = cntCur;
    if (upd_taken) begin
      if (cntCur != CNT_MAX) cntNext = cntCur + CNT_W'(1);
    end else begin
      if (cntCur != '0) cntNext = cntCur - CNT_W'(1);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < ENTRIES; i++) begin
        validQ[i]  <= 1'b0;
        tagQ[i]    <= '0;
        targetQ[i] <= '0;
        cntQ[i]    <= CNT_WEAK_NT;
        jumpQ[i]   <= 1'b0;
      end
      stat_branches    <= '0;
      stat_mispredicts <= '0;
    end else begin
      if (upd_valid) begin
        if (stat_branches != STAT_MAX) stat_branches <= stat_branches + STAT_W'(1);
        if (mispredict && stat_mispredicts != STAT_MAX)
          stat_mispredicts <= stat_mispredicts + STAT_W'(1);
      end
      // Flush takes priority: no table writes happen on a flush edge.
      if (flush_tables) begin
        for (int i = 0; i < ENTRIES; i++) validQ[i] <= 1'b0;
      end else if (upd_valid) begin
        if (upd_no_alloc) begin
          if (updHit) validQ[updIdx] <= 1'b0;
        end else if (updHit) begin
          cntQ[updIdx]  <= cntNext;
          jumpQ[updIdx] <= upd_is_jump;
          if (upd_taken) targetQ[updIdx] <= upd_target;
        end else if (upd_taken) begin
          validQ[updIdx]  <= 1'b1;
          tagQ[updIdx]    <= updTag;
          targetQ[updIdx] <= upd_target;
          cntQ[updIdx]    <= CNT_WEAK_T;
          jumpQ[updIdx]   <= upd_is_jump;
        end
      end
    end
  end

endmodule

// File: tb/tb_branch_predictor_btb.sv
// tb/tb_branch_predictor_btb.sv - scoreboard bench for branch_predictor_btb
// Small stats width so saturation is reachable; expected values come from a behavioural model.
module tb_branch_predictor_btb;

  localparam int STAT_W = 4;
  localparam int SMAX   = 15;

  logic        clock = 0;
  logic        reset;
  logic        flush_tables;
  logic [31:0] if_pc;
  logic        pred_hit, pred_taken;
  logic [31:0] pred_target;
  logic        upd_valid, upd_is_jump, upd_no_alloc, upd_taken, upd_pred_taken;
  logic [31:0] upd_pc, upd_target, upd_pred_target;
  logic        mispredict;
  logic [31:0] redirect_pc;
  logic [STAT_W-1:0] stat_branches, stat_mispredicts;

  branch_predictor_btb #(.XLEN(32), .ENTRIES(16), .TAG_W(8), .CNT_W(2), .STAT_W(STAT_W)) dut (
    .clock(clock), .reset(reset), .flush_tables(flush_tables), .if_pc(if_pc),
    .pred_hit(pred_hit), .pred_taken(pred_taken), .pred_target(pred_target),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_is_jump(upd_is_jump),
    .upd_no_alloc(upd_no_alloc), .upd_taken(upd_taken), .upd_target(upd_target),
    .upd_pred_taken(upd_pred_taken), .upd_pred_target(upd_pred_target),
    .mispredict(mispredict), .redirect_pc(redirect_pc),
    .stat_branches(stat_branches), .stat_mispredicts(stat_mispredicts)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic        hit;
    logic        taken;
    logic [31:0] target;
    logic        mis;
    logic [31:0] redir;
    logic [3:0]  sb;
    logic [3:0]  sm;
  } exp_t;

  exp_t expQ[$];
  int   nChecks = 0;
  int   nErrors = 0;

  logic        mValid  [16];
  logic [7:0]  mTag    [16];
  logic [31:0] mTarget [16];
  int          mCnt    [16];
  logic        mJump   [16];
  int          mStatB, mStatM;

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nChecks++;
    if (got !== exp) begin
      nErrors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic modelReset();
    for (int i = 0; i < 16; i++) begin
      mValid[i] = 0; mTag[i] = 0; mTarget[i] = 0; mCnt[i] = 1; mJump[i] = 0;
    end
    mStatB = 0; mStatM = 0;
  endtask

  task automatic modelLookup(input logic [31:0] pc, output logic h, output logic t,
                             output logic [31:0] tg);
    int i;
    i  = int'((pc >> 2) & 32'hf);
    h  = mValid[i] && (mTag[i] == pc[13:6]);
    t  = h && (mJump[i] || mCnt[i] >= 2);
    tg = t ? mTarget[i] : pc + 32'd4;
  endtask

  function automatic logic modelMis();
    return upd_valid && ((upd_taken != upd_pred_taken) ||
                         (upd_taken && upd_target != upd_pred_target));
  endfunction

  task automatic modelUpdate();
    int i;
    logic h;
    i = int'((upd_pc >> 2) & 32'hf);
    h = mValid[i] && (mTag[i] == upd_pc[13:6]);
    if (upd_valid) begin
      if (mStatB < SMAX) mStatB++;
      if (modelMis() && mStatM < SMAX) mStatM++;
    end
    if (flush_tables) begin
      for (int k = 0; k < 16; k++) mValid[k] = 0;
    end else if (upd_valid) begin
      if (upd_no_alloc) begin
        if (h) mValid[i] = 0;
      end else if (h) begin
        if (upd_taken) begin
          if (mCnt[i] < 3) mCnt[i]++;
          mTarget[i] = upd_target;
        end else if (mCnt[i] > 0) mCnt[i]--;
        mJump[i] = upd_is_jump;
      end else if (upd_taken) begin
        mValid[i] = 1; mTag[i] = upd_pc[13:6]; mTarget[i] = upd_target;
        mCnt[i] = 2; mJump[i] = upd_is_jump;
      end
    end
  endtask

  // Called just after a negedge with inputs already driven; leaves at the next negedge.
  task automatic cycle();
    exp_t e;
    #1;
    modelLookup(if_pc, e.hit, e.taken, e.target);
    e.mis   = modelMis();
    e.redir = upd_taken ? upd_target : upd_pc + 32'd4;
    e.sb    = 4'(mStatB);
    e.sm    = 4'(mStatM);
    expQ.push_back(e);
    e = expQ.pop_front();
    checkVal("pred_hit", {31'b0, pred_hit}, {31'b0, e.hit});
    checkVal("pred_taken", {31'b0, pred_taken}, {31'b0, e.taken});
    checkVal("pred_target", pred_target, e.target);
    checkVal("mispredict", {31'b0, mispredict}, {31'b0, e.mis});
    if (e.mis) checkVal("redirect_pc", redirect_pc, e.redir);
    checkVal("stat_branches", {28'b0, stat_branches}, {28'b0, e.sb});
    checkVal("stat_mispredicts", {28'b0, stat_mispredicts}, {28'b0, e.sm});
    @(posedge clock);
    modelUpdate();
    @(negedge clock);
  endtask

  task automatic setUpd(input logic [31:0] pc, input logic tk, input logic [31:0] tgt,
                        input logic jmp, input logic na);
    logic h, pt;
    logic [31:0] ptg;
    modelLookup(pc, h, pt, ptg);
    upd_valid = 1; upd_pc = pc; upd_taken = tk; upd_target = tgt;
    upd_is_jump = jmp; upd_no_alloc = na; upd_pred_taken = pt; upd_pred_target = ptg;
  endtask

  task automatic branch(input logic [31:0] pc, input logic tk, input logic [31:0] tgt,
                        input logic jmp, input logic na);
    setUpd(pc, tk, tgt, jmp, na);
    cycle();
    upd_valid = 0;
  endtask

  task automatic lookupCheck(input logic [31:0] pc, input string tag, input logic expHit);
    if_pc = pc;
    #1 checkVal(tag, {31'b0, pred_hit}, {31'b0, expHit});
    cycle();
  endtask

  initial begin
    logic [31:0] pcs [5];
    pcs[0] = 32'h100; pcs[1] = 32'h140; pcs[2] = 32'h200; pcs[3] = 32'h300; pcs[4] = 32'h1044;

    reset = 1; flush_tables = 0; if_pc = 32'h100;
    upd_valid = 0; upd_pc = 0; upd_is_jump = 0; upd_no_alloc = 0; upd_taken = 0;
    upd_target = 0; upd_pred_taken = 0; upd_pred_target = 0;
    modelReset();
    @(negedge clock); @(negedge clock);
    checkVal("rst_hit", {31'b0, pred_hit}, 32'd0);
    checkVal("rst_taken", {31'b0, pred_taken}, 32'd0);
    checkVal("rst_target", pred_target, 32'h104);
    checkVal("rst_stats", {24'b0, stat_branches, stat_mispredicts}, 32'd0);
    reset = 0;
    cycle();

    // First taken resolution allocates and mispredicts
    if_pc = 32'h100;
    setUpd(32'h100, 1, 32'h40, 0, 0);
    #1 checkVal("tp_mis", {31'b0, mispredict}, 32'd1);
    checkVal("tp_redir", redirect_pc, 32'h40);
    cycle();
    upd_valid = 0;
    #1 checkVal("tp_alloc_target", pred_target, 32'h40);
    checkVal("tp_stat_mis", {28'b0, stat_mispredicts}, 32'd1);
    cycle();

    // Counter training at 0x200: saturate high then walk down past zero
    if_pc = 32'h200;
    for (int k = 0; k < 3; k++) branch(32'h200, 1, 32'h600, 0, 0);
    for (int k = 0; k < 2; k++) branch(32'h200, 0, 32'h600, 0, 0);
    #1 checkVal("tp_nt_taken", {31'b0, pred_taken}, 32'd0);
    checkVal("tp_nt_target", pred_target, 32'h204);
    cycle();
    for (int k = 0; k < 2; k++) branch(32'h200, 0, 32'h600, 0, 0);
    branch(32'h200, 1, 32'h600, 0, 0);

    // Aliasing: same index, different tag evicts the occupant
    branch(32'h140, 1, 32'h80, 0, 0);
    lookupCheck(32'h100, "alias_old_miss", 0);
    lookupCheck(32'h140, "alias_new_hit", 1);

    // Register-target jumps never allocate, and invalidate an existing entry
    branch(32'h300, 1, 32'h80, 1, 1);
    lookupCheck(32'h300, "jalr_no_alloc", 0);
    branch(32'h300, 1, 32'h90, 1, 0);
    lookupCheck(32'h300, "jal_alloc", 1);
    branch(32'h300, 1, 32'h80, 1, 1);
    lookupCheck(32'h300, "jalr_inval", 0);

    // Flush on the same edge as an update
    flush_tables = 1;
    branch(32'h200, 1, 32'h700, 0, 0);
    flush_tables = 0;
    lookupCheck(32'h140, "flush_miss_a", 0);
    lookupCheck(32'h200, "flush_miss_b", 0);

    // Mixed traffic, enough to saturate the narrow stats counters
    for (int k = 0; k < 30; k++) begin
      if_pc = pcs[$urandom_range(0, 4)];
      branch(pcs[$urandom_range(0, 4)], 1'($urandom_range(0, 1)),
             32'h1000 + 32'($urandom_range(0, 3)) * 32'h10, 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 5) == 0));
    end
    #1 checkVal("stat_sat", {28'b0, stat_branches}, 32'd15);
    cycle();
    branch(32'h100, 1, 32'h44, 0, 0);
    #1 checkVal("stat_hold", {28'b0, stat_branches}, 32'd15);
    cycle();

    // Asynchronous reset mid-cycle drops the in-flight update
    if_pc = 32'h100;
    setUpd(32'h100, 1, 32'h44, 0, 0);
    #2 reset = 1;
    #1 checkVal("async_rst_hit", {31'b0, pred_hit}, 32'd0);
    checkVal("async_rst_stat", {28'b0, stat_branches}, 32'd0);
    modelReset();
    @(negedge clock);
    reset = 0; upd_valid = 0;
    lookupCheck(32'h100, "post_rst_miss", 0);

    $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
    $finish;
  end

endmodule

// File: doc/branch_predictor_btb.md
Name: branch_predictor_btb

Overview:
Parametrised dynamic branch predictor with a direct-mapped branch target buffer. It replaces the core's fixed "predict not-taken, flush when resolved in MEM" scheme.
- IF stage: looks up the fetch PC in the same cycle and supplies the predicted next PC.
- MEM stage: reports resolved control-flow outcomes back. The block updates its saturating counters and targets, and flags mispredictions so the core can redirect and flush.
- Keeps saturating performance counters.

Parameters:
XLEN, 32, address/data width
ENTRIES, 16, BTB entries; power of 2, min 2; IDX_W = log2(ENTRIES)
TAG_W, 8, tag bits stored per entry
CNT_W, 2, saturating direction counter width; min 1
STAT_W, 32, performance counter width

Ports:
clock  in  1  clock, all state updates on rising edge
reset  in  1  asynchronous, active-high
flush_tables  in  1  synchronous invalidate of all entries
if_pc  in  XLEN  fetch PC to look up
pred_hit  out  1  valid entry with matching tag
pred_taken  out  1  predicted taken
pred_target  out  XLEN  predicted next PC
upd_valid  in  1  resolved control-flow instruction present in MEM
upd_pc  in  XLEN  PC of resolved instruction
upd_is_jump  in  1  unconditional (jal)
upd_no_alloc  in  1  jalr or other register-target instruction; never cached
upd_taken  in  1  actual outcome
upd_target  in  XLEN  actual taken target
upd_pred_taken  in  1  prediction carried down the pipeline
upd_pred_target  in  XLEN  predicted target carried down the pipeline
mispredict  out  1  redirect/flush request
redirect_pc  out  XLEN  correct next PC when mispredict=1
stat_branches  out  STAT_W  resolved updates counted
stat_mispredicts  out  STAT_W  mispredictions counted

Behaviour:
- Reset is asynchronous and clears the following:
  - all valid bits = 0
  - counters = 2^(CNT_W-1)-1 (weakly not-taken)
  - tags and targets = 0
  - stats = 0
- Resulting outputs under reset: pred_hit=0, pred_taken=0, pred_target=if_pc+4.
- Index = pc[IDX_W+1:2]; tag = pc[IDX_W+TAG_W+1:IDX_W+2]. pc[1:0] is ignored.
- Lookup is combinational, zero latency:
  - pred_hit = valid & tag match.
  - pred_taken = pred_hit & (is_jump | counter MSB).
  - pred_target = stored target if pred_taken, else if_pc+4 (mod 2^XLEN).
- Mispredict is combinational on the update inputs:
  - mispredict = upd_valid & ((upd_taken != upd_pred_taken) | (upd_taken & upd_target != upd_pred_target)).
  - redirect_pc = upd_taken ? upd_target : upd_pc+4.
  - With upd_valid=0, mispredict=0.
- Update occurs on a clock edge with upd_valid=1. Entry selected by upd_pc:
  - upd_no_alloc=1: a hit invalidates the entry; a miss leaves it untouched; no other change.
  - Hit: counter +1 if taken, -1 if not taken, saturating at 0 and 2^CNT_W-1. is_jump <= upd_is_jump. Target <= upd_target only when taken.
  - Miss and taken: allocate (overwrite any occupant). Valid=1, tag, target, is_jump set; counter = 2^(CNT_W-1) (weakly taken).
  - Miss and not taken: no change.
- Stats, on every upd_valid edge:
  - stat_branches +1.
  - stat_mispredicts +1 if mispredict.
  - Both saturate at all-ones; no wrap.
- Simultaneous lookup and update to the same index: lookup returns pre-edge contents; no bypass.
- flush_tables together with upd_valid: flush wins for valid bits. Stats still update; counters/targets are not written.
- Reset asserted mid-operation clears state immediately; any in-flight update is dropped.
- CNT_W=1: counter is a single last-outcome bit; increment sets it, decrement clears it.

Test Plan:
- Reset, if_pc=0x100 -> pred_hit=0, pred_taken=0, pred_target=0x104; stats=0.
- Update pc=0x100, taken, target=0x40, pred_taken=0 -> mispredict=1, redirect_pc=0x40. Next cycle lookup 0x100 -> hit, taken, target 0x40 (counter=2). stat_mispredicts=1.
- Branch pc=0x200 trained taken 3x (counter saturates at 3), then not taken 2x -> counter 1, lookup predicts not-taken, pred_target=0x204. A further not-taken leaves counter 0; one more not-taken stays at 0.
- Aliasing: allocate pc=0x100, then taken update pc=0x100+4*ENTRIES (same index, different tag) -> lookup 0x100 misses; new pc hits.
- jalr: upd_no_alloc=1, taken, target=0x80 at pc=0x300 -> no allocation, and lookup 0x300 misses. If 0x300 was previously cached, the entry is invalidated.
- flush_tables pulse and update on the same edge -> all lookups miss afterwards; stat_branches still increments. Counters forced to all-ones, then one more update -> value holds.
